comp_freq_seq_gen: RTL

- Parametrised successor to the challenge-driven TERO frequency-index counter.
- Decodes a challenge into an ordered pair of TERO groups (a < b).
- Streams every TERO index of both groups across all columns over a valid/ready handshake, in either of two scan orders.
- Sits between the challenge register and the TERO mux/frequency-measurement controller. Adds an iterative pair decoder, back-pressure, an out-of-range error and a column-major mode.

---
 rtl/comp_freq_seq_gen.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/comp_freq_seq_gen.sv
// Challenge-driven TERO index sequencer: decodes a challenge into a group pair (a < b)
// and streams every TERO index of both groups over all columns on a valid/ready port.
module comp_freq_seq_gen #(
  parameter int N_GROUPS   = 16,
  parameter int GROUP_SIZE = 8,
  parameter int N_COLS     = 10,
  parameter int CH_W       = 8,
  parameter int IDX_W      = 11
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CH_W-1:0]             challenge_in,
  input  logic                        start,
  input  logic                        mode,
  output logic [IDX_W-1:0]            tero_idx,
  output logic                        idx_valid,
  input  logic                        idx_ready,
  output logic [$clog2(N_GROUPS)-1:0] grp_a,
  output logic [$clog2(N_GROUPS)-1:0] grp_b,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int GW = $clog2(N_GROUPS);
  localparam int RW = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int DW = CH_W + GW + 1;
  localparam logic [DW-1:0]    N_PAIRS    = DW'(N_GROUPS * (N_GROUPS - 1) / 2);
  localparam logic [IDX_W-1:0] COL_STRIDE = IDX_W'(N_GROUPS * GROUP_SIZE);
  localparam logic [RW-1:0]    R_LAST     = RW'(GROUP_SIZE - 1);
  localparam logic [CW-1:0]    C_LAST     = CW'(N_COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EMIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic [IDX_W-1:0] grp_base(input logic [GW-1:0] g);
    grp_base = IDX_W'(g) * IDX_W'(GROUP_SIZE);
  endfunction

  state_t            state_q, state_d;
  logic [GW-1:0]     i_q, i_d;
  logic [CH_W-1:0]   rem_q, rem_d;
  logic              mode_q, mode_d;
  logic              gsel_q, gsel_d;
  logic [RW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [IDX_W-1:0]  col_off_q, col_off_d;
  logic [IDX_W-1:0]  tero_idx_q, tero_idx_d;
  logic              idx_valid_q, idx_valid_d;
  logic [GW-1:0]     grp_a_q, grp_a_d;
  logic [GW-1:0]     grp_b_q, grp_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [DW-1:0]     lim_s;
  logic              c_last_s, r_last_s, step_c_s, step_r_s, grp_end_s;

  // Next-state logic for the FSM, decode iterator and scan counters.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    rem_d       = rem_q;
    mode_d      = mode_q;
    gsel_d      = gsel_q;
    r_d         = r_q;
    c_d         = c_q;
    col_off_d   = col_off_q;
    tero_idx_d  = tero_idx_q;
    idx_valid_d = idx_valid_q;
    grp_a_d     = grp_a_q;
    grp_b_d     = grp_b_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;

    lim_s     = DW'(N_GROUPS - 1) - DW'(i_q);
    c_last_s  = (c_q == C_LAST);
    r_last_s  = (r_q == R_LAST);
    // The inner loop always steps; the outer one steps when the inner wraps.
    step_c_s  = mode_q ? r_last_s : 1'b1;
    step_r_s  = mode_q ? 1'b1 : c_last_s;
    grp_end_s = c_last_s && r_last_s;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d  = mode;
          done_d  = 1'b0;
          err_d   = 1'b0;
          grp_a_d = {GW{1'b0}};
          grp_b_d = {GW{1'b0}};
          if (DW'(challenge_in) >= N_PAIRS) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_DECODE;
            i_d     = {GW{1'b0}};
            rem_d   = challenge_in;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DECODE: begin
        if (DW'(rem_q) < lim_s) begin
          grp_a_d     = i_q;
          grp_b_d     = i_q + GW'(1) + GW'(rem_q);
          gsel_d      = 1'b0;
          r_d         = {RW{1'b0}};
          c_d         = {CW{1'b0}};
          col_off_d   = {IDX_W{1'b0}};
          tero_idx_d  = grp_base(i_q);
          idx_valid_d = 1'b1;
          state_d     = S_EMIT;
        end else begin
          rem_d = rem_q - lim_s[CH_W-1:0];
          i_d   = i_q + GW'(1);
        end
      end
      S_EMIT: begin
        if (idx_valid_q && idx_ready) begin
          if (step_c_s) begin
            c_d       = c_last_s ? {CW{1'b0}} : c_q + CW'(1);
            col_off_d = c_last_s ? {IDX_W{1'b0}} : col_off_q + COL_STRIDE;
          end else begin
            c_d       = c_q;
          end
          if (step_r_s) begin
            r_d = r_last_s ? {RW{1'b0}} : r_q + RW'(1);
          end else begin
            r_d = r_q;
          end
          if (grp_end_s && gsel_q) begin
            state_d     = S_DONE;
            idx_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            gsel_d     = gsel_q | grp_end_s;
            tero_idx_d = col_off_d + grp_base((gsel_q | grp_end_s) ? grp_b_q : grp_a_q)
                         + IDX_W'(r_d);
          end
        end else begin
          tero_idx_d = tero_idx_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      i_q         <= {GW{1'b0}};
      rem_q       <= {CH_W{1'b0}};
      mode_q      <= 1'b0;
      gsel_q      <= 1'b0;
      r_q         <= {RW{1'b0}};
      c_q         <= {CW{1'b0}};
      col_off_q   <= {IDX_W{1'b0}};
      tero_idx_q  <= {IDX_W{1'b0}};
      idx_valid_q <= 1'b0;
      grp_a_q     <= {GW{1'b0}};
      grp_b_q     <= {GW{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      rem_q       <= rem_d;
      mode_q      <= mode_d;
      gsel_q      <= gsel_d;
      r_q         <= r_d;
      c_q         <= c_d;
      col_off_q   <= col_off_d;
      tero_idx_q  <= tero_idx_d;
      idx_valid_q <= idx_valid_d;
      grp_a_q     <= grp_a_d;
      grp_b_q     <= grp_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign tero_idx  = tero_idx_q;
  assign idx_valid = idx_valid_q;
  assign grp_a     = grp_a_q;
  assign grp_b     = grp_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
